rom_loader_fifo: RTL and testbench
==================================

# rom_loader_fifo

Buffered ROM/BIOS download stage between the HPS ioctl port and the SDRAM controller write port. Packs 16-bit `ioctl_dout` halfwords into 32-bit little-endian words and queues them in a small FIFO. Drains them to SDRAM over the toggle `we_req`/`we_ack` handshake. `ioctl_wait` asserts only on FIFO-full rather than on every word, so the host is stalled far less often. The core top level muxes `sdram_waddr`/`sdram_din`/`sdram_we_req` from this block while `busy` is high.

## Interface
- `DEPTH`, 4: FIFO depth in 32-bit words; power of two, ≥2.
- `INDEX_MAX`, 6'h01: download accepted when `ioctl_index[5:0] <= INDEX_MAX`.
- `BASE_ADDR`, 25'h0: SDRAM byte address of first word.
- `clk_sys` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: host download active.
- `ioctl_index` in 8: download slot index.
- `ioctl_wr` in 1: one-cycle halfword strobe.
- `ioctl_dout` in 16: halfword data.
- `ioctl_wait` out 1: host must hold further writes.
- `sdram_waddr` out 25: word byte-address; bits [1:0] always 0.
- `sdram_din` out 32: word data.
- `sdram_we_req` out 1: toggle request.
- `sdram_we_ack` in 1: toggle acknowledge. Transfer is complete when it equals `sdram_we_req`.
- `busy` out 1: block owns the SDRAM write port.
- `overflow` out 1: sticky; a word was dropped.

## Operation
- `active = ioctl_download & (ioctl_index[5:0] <= INDEX_MAX)`. The block registers `active` and detects its edges.
- **Rising edge of active:**
  - If the drain is idle, clear the pack phase, FIFO pointers, drain address counter and `overflow`.
  - If the drain is not idle, hold `ioctl_wait`=1 until the drain is idle, then clear.
- **Packing:**
  - `ioctl_wr & active` with phase 0 latches `ioctl_dout` into the low half; phase becomes 1.
  - With phase 1, push `{ioctl_dout, low}`; phase becomes 0.
- **Falling edge of active with phase 1:** push `{16'hFFFF, low}` and set phase to 0. An odd tail is padded with erased-ROM value.
- **Full FIFO:** a push when the FIFO is full drops the word and sets `overflow`. The count is not changed.
- **Drain FSM:**
  - IDLE: if FIFO is non-empty and `sdram_we_ack == sdram_we_req`, drive `sdram_din` = head and `sdram_waddr` = `BASE_ADDR + {drain_cnt, 2'b00}`, toggle `sdram_we_req`, go to WAIT.
  - WAIT: when `sdram_we_ack == sdram_we_req`, pop the head, increment `drain_cnt`, go to IDLE.
  - Address and data stay stable throughout WAIT.
- **Arithmetic:** `drain_cnt` is 23 bits and wraps modulo 2^23. The address add is modulo 2^25.
- **`ioctl_wait`:**
  - Registered.
  - Set when count ≥ DEPTH-1 and phase = 1, so the next completing halfword still fits.
  - Set during a rising-edge hold.
  - Cleared when neither condition holds.
- **`busy`** = `active_q` | FIFO non-empty | state == WAIT.
- **Simultaneous push and pop:** both are applied in the same cycle; count is unchanged; no overflow.
- **Reset values:**
  - `ioctl_wait`=0, `sdram_we_req`=0, `busy`=0, `overflow`=0, `sdram_waddr`=`BASE_ADDR`, `sdram_din`=0.
  - FIFO empty, state IDLE.
- **Reset mid-transfer:** all state returns to reset values. The first request after reset waits until `sdram_we_ack` equals 0, so a stale ack is absorbed.

## Timing
- Push occurs on the edge after the phase-1 `ioctl_wr`.
- Request toggle occurs on the following edge at the earliest, when the FIFO was empty and the drain was idle.
- Word latency from the phase-1 strobe to `sdram_we_req` toggling is 2 clocks minimum.
- Pop occurs on the edge after ack matches. The next request can toggle 1 clock after the pop, giving 1 idle cycle between transfers.
- `ioctl_wait` rises on the edge following the condition. The host sees it within 1 clock, which is covered by the DEPTH-1 threshold.
- Falling-edge pad push occurs 1 clock after `active` drops.
- `busy` stays high until the last ack is seen.

## Configuration
- `ROMLDR_SIZE_EN`: when defined, adds output `rom_mask` (24 bits).
  - Updated on the falling edge of `active` to 2^ceil(log2(bytes_pushed)) − 1, with a minimum of 3.
  - Reset value 24'h3.
  - `bytes_pushed` counts 4 per push, including the pad word.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- **Back-to-back halfwords, immediate ack:** host writes 8 halfwords 0x1111..0x8888 with 1-cycle ack → 4 writes of 0x22221111 @0, 0x44443333 @4, 0x66665555 @8, 0x88887777 @C; `ioctl_wait` never high.
- **Stalled ack (ack withheld 50 clocks):** host streams halfwords → `ioctl_wait` rises when 3 words are queued and phase = 1; no word lost; `overflow`=0; data order preserved after ack resumes.
- **Odd tail:** 3 halfwords 0xAAAA, 0xBBBB, 0xCCCC, then download drops → second word 0xFFFFCCCC @4; `busy` falls after its ack.
- **Wrong index:** download with `ioctl_index`=8'h02 and writes → no request toggles; `busy`=0.
- **Reset during WAIT with ack high:** assert `reset` → `sdram_we_req`=0; no new request until ack=0; the next download starts at address 0.
- **`ROMLDR_SIZE_EN`:** load 5 words (20 bytes) → `rom_mask`=24'h1F.

Source files
------------

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo: buffered ROM/BIOS download stage.
// Packs 16-bit ioctl halfwords into 32-bit little-endian words, queues them
// in a small FIFO and drains them to the SDRAM write port over a toggle
// request/acknowledge handshake. The host is stalled only when the FIFO is
// about to fill.
// Optional feature: define ROMLDR_SIZE_EN to add the rom_mask output, which
// reports the power-of-two size mask of the last completed download.
module rom_loader_fifo #(
    parameter int          DEPTH     = 4,
    parameter logic [5:0]  INDEX_MAX = 6'h01,
    parameter logic [24:0] BASE_ADDR = 25'h0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:0] sdram_waddr,
    output logic [31:0] sdram_din,
    output logic        sdram_we_req,
    input  logic        sdram_we_ack,
    output logic        busy,
`ifdef ROMLDR_SIZE_EN
    output logic [23:0] rom_mask,
`endif
    output logic        overflow
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]  WAIT_THR = (AW+1)'(DEPTH - 1);

    typedef enum logic [0:0] {S_IDLE, S_WAIT} drain_state_t;

    // Word storage; read is registered straight into sdram_din.
    logic [31:0]   mem [DEPTH];

    logic          active;
    logic          active_reg;
    logic          rise;
    logic          fall;

    logic          phase_reg, phase_next, phase_cur;
    logic [15:0]   low_reg, low_next;
    logic          hold_reg, hold_next;
    logic          wait_reg, wait_next;
    logic          overflow_reg;

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;

    logic [22:0]   drain_cnt_reg;
    drain_state_t  state_reg;
    logic          req_reg;
    logic [24:0]   waddr_reg;
    logic [31:0]   din_reg;

    logic          drain_idle;
    logic          clear;
    logic          wr_en;
    logic          push;
    logic [31:0]   push_data;
    logic          push_ok;
    logic          drop;
    logic          pop;

    // Only the low six index bits select a slot; the top two are don't-care.
    logic          unused_index;
    assign unused_index = ^ioctl_index[7:6];

    assign active     = ioctl_download & (ioctl_index[5:0] <= INDEX_MAX);
    assign rise       = active & ~active_reg;
    assign fall       = ~active & active_reg;
    assign drain_idle = (count_reg == '0) && (state_reg == S_IDLE);
    // A new download restarts the block only once the previous one has fully
    // drained; until then the host is held off.
    assign clear      = drain_idle & (rise | hold_reg);
    assign pop        = (state_reg == S_WAIT) && (sdram_we_ack == req_reg);
    assign push_ok    = push & ((count_reg != DEPTH_C) | pop);
    assign drop       = push & ~push_ok;

    // Next-state logic for packing, restart hold, occupancy and host stall.
    always_comb begin
        hold_next = hold_reg;
        if (clear)
            hold_next = 1'b0;
        else if (rise)
            hold_next = 1'b1;

        phase_cur  = clear ? 1'b0 : phase_reg;
        wr_en      = ioctl_wr & active & ~hold_next;
        phase_next = phase_cur;
        low_next   = low_reg;
        push       = 1'b0;
        push_data  = 32'h0;
        if (wr_en) begin
            if (!phase_cur) begin
                low_next   = ioctl_dout;
                phase_next = 1'b1;
            end else begin
                push       = 1'b1;
                push_data  = {ioctl_dout, low_reg};
                phase_next = 1'b0;
            end
        end else if (fall && phase_cur) begin
            // Odd tail: pad the upper half with the erased-ROM value.
            push       = 1'b1;
            push_data  = {16'hFFFF, low_reg};
            phase_next = 1'b0;
        end

        if (clear)
            count_next = '0;
        else
            count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);

        // Evaluated on the state this edge produces, so the stall is visible
        // before the host could issue the halfword that would not fit.
        wait_next = hold_next | ((count_next >= WAIT_THR) & phase_next);
    end

    // Packing state, FIFO pointers, stall and overflow flags.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active_reg   <= 1'b0;
            phase_reg    <= 1'b0;
            low_reg      <= 16'h0;
            hold_reg     <= 1'b0;
            wait_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            active_reg <= active;
            phase_reg  <= phase_next;
            low_reg    <= low_next;
            hold_reg   <= hold_next;
            wait_reg   <= wait_next;
            count_reg  <= count_next;
            if (clear) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push_ok)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (drop)
                    overflow_reg <= 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data;
    end

    // Drain FSM: issue one toggle request per queued word, pop on acknowledge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            req_reg       <= 1'b0;
            waddr_reg     <= BASE_ADDR;
            din_reg       <= 32'h0;
            drain_cnt_reg <= 23'h0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (clear) begin
                        drain_cnt_reg <= 23'h0;
                    end else if ((count_reg != '0) && (sdram_we_ack == req_reg)) begin
                        din_reg   <= mem[rd_ptr_reg];
                        waddr_reg <= BASE_ADDR + {drain_cnt_reg, 2'b00};
                        req_reg   <= ~req_reg;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_we_ack == req_reg) begin
                        drain_cnt_reg <= drain_cnt_reg + 23'h1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef ROMLDR_SIZE_EN
    logic [24:0] bytes_reg;
    logic [24:0] bytes_total;
    logic [24:0] bytes_m1;
    logic [23:0] smear;
    logic [23:0] mask_reg;

    assign bytes_total = bytes_reg + (push ? 25'd4 : 25'd0);
    assign bytes_m1    = bytes_total - 25'd1;

    // Round up to the next power of two minus one by smearing the top set bit.
    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_smear
            assign smear[gi] = |(bytes_m1 >> gi);
        end
    endgenerate

    // Byte counter per download and size mask latched when the download ends.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bytes_reg <= 25'h0;
            mask_reg  <= 24'h3;
        end else begin
            if (clear)
                bytes_reg <= 25'h0;
            else if (push)
                bytes_reg <= bytes_total;
            if (fall) begin
                if (bytes_total <= 25'd4)
                    mask_reg <= 24'h3;
                else
                    mask_reg <= smear | 24'h3;
            end
        end
    end

    assign rom_mask = mask_reg;
`endif

    assign ioctl_wait   = wait_reg;
    assign sdram_waddr  = waddr_reg;
    assign sdram_din    = din_reg;
    assign sdram_we_req = req_reg;
    assign overflow     = overflow_reg;
    assign busy         = active_reg | (count_reg != '0) | (state_reg == S_WAIT);

endmodule

// File: tb/tb_rom_loader_fifo.sv
// Self-checking bench for rom_loader_fifo: directed download sequences with
// an SDRAM acknowledge model and a capture log of every write request.
module tb_rom_loader_fifo;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [24:0] sdram_waddr;
    logic [31:0] sdram_din;
    logic        sdram_we_req;
    logic        sdram_we_ack;
    logic        busy;
    logic        overflow;
`ifdef ROMLDR_SIZE_EN
    logic [23:0] rom_mask;
`endif

    rom_loader_fifo dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sdram_waddr    (sdram_waddr),
        .sdram_din      (sdram_din),
        .sdram_we_req   (sdram_we_req),
        .sdram_we_ack   (sdram_we_ack),
        .busy           (busy),
`ifdef ROMLDR_SIZE_EN
        .rom_mask       (rom_mask),
`endif
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [24:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [4];
    int          total = 0;
    int          bad   = 0;
    logic [24:0] cap_addr [$];
    logic [31:0] cap_data [$];
    logic        prev_req;
    bit          ack_en = 1'b1;
    bit          wait_any;
    bit          wait_rec;
    int          wait_at;
    int          hw_written;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Host halfword write; an obedient host holds off while ioctl_wait is high.
    task automatic write_hw(input logic [15:0] d, input bit obey);
        int n;
        n = 0;
        if (obey) begin
            while (ioctl_wait && n < 300) begin
                if (!wait_rec) begin
                    wait_rec = 1'b1;
                    wait_at  = hw_written;
                end
                tick(1);
                n++;
            end
            if (n >= 300) begin
                total++;
                bad++;
                $display("FAIL host_wait_timeout: ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, n);
            end
        end
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick(1);
        ioctl_wr   = 1'b0;
        hw_written++;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        cap_addr.delete();
        cap_data.delete();
        wait_any   = 1'b0;
        wait_rec   = 1'b0;
        wait_at    = -1;
        hw_written = 0;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: busy=1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic end_dl(input string name);
        ioctl_download = 1'b0;
        tick(1);
        wait_idle(name);
    endtask

    // SDRAM controller model: acknowledge each request in the following cycle.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (ack_en && !reset && (sdram_we_ack !== sdram_we_req))
                sdram_we_ack = sdram_we_req;
        end
    end

    // Capture every request toggle as one SDRAM write transaction.
    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ioctl_wait === 1'b1)
                wait_any = 1'b1;
            if (reset) begin
                prev_req = sdram_we_req;
            end else if (sdram_we_req !== prev_req) begin
                cap_addr.push_back(sdram_waddr);
                cap_data.push_back(sdram_din);
                prev_req = sdram_we_req;
                $display("sdram write addr=%h data=%h", sdram_waddr, sdram_din);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{16'h1111, 16'h2222, 25'h0, 32'h22221111};
        vecs[1] = '{16'h3333, 16'h4444, 25'h4, 32'h44443333};
        vecs[2] = '{16'h5555, 16'h6666, 25'h8, 32'h66665555};
        vecs[3] = '{16'h7777, 16'h8888, 25'hC, 32'h88887777};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 16'h0;
        sdram_we_ack   = 1'b0;
        tick(3);
        check("rst_wait",  {31'h0, ioctl_wait},   32'h0);
        check("rst_req",   {31'h0, sdram_we_req}, 32'h0);
        check("rst_busy",  {31'h0, busy},         32'h0);
        check("rst_ovf",   {31'h0, overflow},     32'h0);
        check("rst_waddr", {7'h0, sdram_waddr},   32'h0);
        check("rst_din",   sdram_din,             32'h0);
`ifdef ROMLDR_SIZE_EN
        check("rst_mask",  {8'h0, rom_mask},      32'h3);
`endif
        reset = 1'b0;
        tick(2);

        // Back-to-back halfwords with immediate acknowledge.
        start_dl(8'h00);
        for (int i = 0; i < 4; i++) begin
            write_hw(vecs[i].lo, 1'b1);
            write_hw(vecs[i].hi, 1'b1);
        end
        end_dl("b2b_idle");
        check("b2b_count", cap_addr.size(), 4);
        for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
            check($sformatf("b2b_addr%0d", i), {7'h0, cap_addr[i]}, {7'h0, vecs[i].addr});
            check($sformatf("b2b_data%0d", i), cap_data[i], vecs[i].data);
        end
        check("b2b_no_wait", {31'h0, wait_any}, 32'h0);
`ifdef ROMLDR_SIZE_EN
        check("b2b_mask", {8'h0, rom_mask}, 32'hF);
`endif

        // Acknowledge withheld for 50 clocks while the host streams.
        ack_en = 1'b0;
        start_dl(8'h01);
        fork
            begin
                for (int k = 0; k < 12; k++)
                    write_hw(16'hA000 + 16'(k), 1'b1);
            end
            begin
                tick(50);
                ack_en = 1'b1;
            end
        join
        end_dl("stall_idle");
        check("stall_wait_at", wait_at, 7);
        check("stall_ovf", {31'h0, overflow}, 32'h0);
        check("stall_count", cap_addr.size(), 6);
        for (int j = 0; j < 6 && j < cap_addr.size(); j++) begin
            check($sformatf("stall_addr%0d", j), {7'h0, cap_addr[j]}, 32'(4 * j));
            check($sformatf("stall_data%0d", j), cap_data[j],
                  {16'hA000 + 16'(2 * j + 1), 16'hA000 + 16'(2 * j)});
        end
`ifdef ROMLDR_SIZE_EN
        check("stall_mask", {8'h0, rom_mask}, 32'h1F);
`endif

        // Odd tail padded with 0xFFFF; busy holds until the final ack.
        start_dl(8'h00);
        write_hw(16'hAAAA, 1'b1);
        write_hw(16'hBBBB, 1'b1);
        write_hw(16'hCCCC, 1'b1);
        ioctl_download = 1'b0;
        tick(1);
        check("tail_busy_high", {31'h0, busy}, 32'h1);
        wait_idle("tail_idle");
        check("tail_ack_done", {31'h0, sdram_we_ack}, {31'h0, sdram_we_req});
        check("tail_count", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            check("tail_data0", cap_data[0], 32'hBBBBAAAA);
            check("tail_addr1", {7'h0, cap_addr[1]}, 32'h4);
            check("tail_data1", cap_data[1], 32'hFFFFCCCC);
        end
`ifdef ROMLDR_SIZE_EN
        check("tail_mask", {8'h0, rom_mask}, 32'h7);
`endif

        // Index out of range: nothing is accepted.
        start_dl(8'h02);
        for (int k = 0; k < 4; k++)
            write_hw(16'h7700 + 16'(k), 1'b1);
        tick(4);
        check("idx_busy", {31'h0, busy}, 32'h0);
        check("idx_count", cap_addr.size(), 0);
        check("idx_wait", {31'h0, ioctl_wait}, 32'h0);
        end_dl("idx_idle");

        // Host ignoring ioctl_wait overruns the FIFO; overflow is sticky.
        ack_en = 1'b0;
        start_dl(8'h00);
        for (int k = 0; k < 10; k++)
            write_hw(16'h5000 + 16'(k), 1'b0);
        tick(2);
        check("ovf_set", {31'h0, overflow}, 32'h1);
        ack_en = 1'b1;
        end_dl("ovf_idle");
        check("ovf_count", cap_addr.size(), 4);
        if (cap_addr.size() == 4)
            check("ovf_data3", cap_data[3], 32'h50075006);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        start_dl(8'h00);
        tick(1);
        check("ovf_cleared", {31'h0, overflow}, 32'h0);
        end_dl("ovf_clr_idle");

        // New download while the drain is still busy: host held, then restart.
        ack_en = 1'b0;
        start_dl(8'h00);
        write_hw(16'h1234, 1'b1);
        write_hw(16'h5678, 1'b1);
        tick(2);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(2);
        check("hold_wait", {31'h0, ioctl_wait}, 32'h1);
        ack_en = 1'b1;
        n = 0;
        while (ioctl_wait && n < 100) begin
            tick(1);
            n++;
        end
        check("hold_release", {31'h0, ioctl_wait}, 32'h0);
        write_hw(16'h9ABC, 1'b1);
        write_hw(16'hDEF0, 1'b1);
        end_dl("hold_idle");
        check("hold_count", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            check("hold_data0", cap_data[0], 32'h56781234);
            check("hold_addr1", {7'h0, cap_addr[1]}, 32'h0);
            check("hold_data1", cap_data[1], 32'hDEF09ABC);
        end

        // Reset during WAIT with a stale acknowledge arriving.
        ack_en = 1'b0;
        start_dl(8'h00);
        write_hw(16'h0001, 1'b1);
        write_hw(16'h0002, 1'b1);
        tick(3);
        check("rst2_pre_req", {31'h0, sdram_we_req}, 32'h1);
        ioctl_download = 1'b0;
        reset          = 1'b1;
        sdram_we_ack   = 1'b1;
        tick(2);
        check("rst2_req",   {31'h0, sdram_we_req}, 32'h0);
        check("rst2_busy",  {31'h0, busy},         32'h0);
        check("rst2_waddr", {7'h0, sdram_waddr},   32'h0);
        reset = 1'b0;
        tick(1);
        start_dl(8'h00);
        write_hw(16'h3333, 1'b1);
        write_hw(16'h4444, 1'b1);
        tick(10);
        check("rst2_stale_hold", {31'h0, sdram_we_req}, 32'h0);
        check("rst2_busy_q", {31'h0, busy}, 32'h1);
        sdram_we_ack = 1'b0;
        n = 0;
        while (cap_addr.size() == 0 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst2_count", cap_addr.size(), 1);
        if (cap_addr.size() == 1) begin
            check("rst2_addr", {7'h0, cap_addr[0]}, 32'h0);
            check("rst2_data", cap_data[0], 32'h44443333);
        end
        ack_en = 1'b1;
        end_dl("rst2_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
